vga_rect_fill_master: RTL

Drawing engine that fills an axis-aligned rectangle of the 640x480 8-bit VGA pixel buffer with one colour. It issues single-byte writes through the video bus-master external interface of `Computer_System`, and sits directly upstream of it. A host-side PIO or FPGA logic supplies the corners and colour, pulses `start`, and waits for `done`.

---
 rtl/vga_draw_pkg.sv | 31 +++
 rtl/vga_rect_fill_master.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_draw_pkg.sv
// Shared types and helpers for the VGA pixel-buffer drawing engines.
package vga_draw_pkg;

    localparam int unsigned PIX_X_W   = 10;
    localparam int unsigned PIX_Y_W   = 9;
    localparam int unsigned ADDR_W    = 30;
    // One buffer row spans 1024 bytes, so y lands at bit 10 of the offset.
    localparam int unsigned ROW_SHIFT = 10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        ADVANCE,
        DONE
    } draw_state_e;

    // Byte address of pixel (x, y): base + (y << 10) + x, wrapping at 2^30.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0]  base,
        input logic [PIX_X_W-1:0] x,
        input logic [PIX_Y_W-1:0] y
    );
        logic [ADDR_W-1:0] row_off;
        logic [ADDR_W-1:0] col_off;
        row_off = {{(ADDR_W - PIX_Y_W - ROW_SHIFT){1'b0}}, y, {ROW_SHIFT{1'b0}}};
        col_off = {{(ADDR_W - PIX_X_W){1'b0}}, x};
        return base + row_off + col_off;
    endfunction

endpackage

// File: rtl/vga_rect_fill_master.sv
// Rectangle fill engine: walks a clipped rectangle in raster order and issues one
// single-byte bus write per pixel, waiting for the bridge acknowledge each time.
module vga_rect_fill_master
    import vga_draw_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h0800_0000,
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PIX_X_W-1:0] x0,
    input  logic [PIX_X_W-1:0] x1,
    input  logic [PIX_Y_W-1:0] y0,
    input  logic [PIX_Y_W-1:0] y1,
    input  logic [7:0]         color,
    output logic               busy,
    output logic               done,
    output logic [29:0]        bus_address,
    output logic               bus_byte_enable,
    output logic               bus_read,
    output logic               bus_write,
    output logic [7:0]         bus_write_data,
    input  logic               bus_acknowledge,
    input  logic [7:0]         bus_read_data
);

    localparam logic [PIX_X_W-1:0] X_END  = PIX_X_W'(WIDTH);
    localparam logic [PIX_X_W-1:0] X_LAST = PIX_X_W'(WIDTH - 1);
    localparam logic [PIX_Y_W-1:0] Y_END  = PIX_Y_W'(HEIGHT);
    localparam logic [PIX_Y_W-1:0] Y_LAST = PIX_Y_W'(HEIGHT - 1);
    localparam logic [PIX_X_W-1:0] X_ONE  = PIX_X_W'(1);
    localparam logic [PIX_Y_W-1:0] Y_ONE  = PIX_Y_W'(1);

    draw_state_e state_q, state_d;

    logic [PIX_X_W-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [PIX_Y_W-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [7:0]         color_q, color_d;
    logic [PIX_X_W-1:0] xl_q, xl_d, xr_q, xr_d, cx_q, cx_d;
    logic [PIX_Y_W-1:0] yt_q, yt_d, yb_q, yb_d, cy_q, cy_d;

    logic [PIX_X_W-1:0] xl_s, xmax_s, xr_s;
    logic [PIX_Y_W-1:0] yt_s, ymax_s, yb_s;

    // Read data is never consumed; the engine only writes.
    logic unused_read_data;
    assign unused_read_data = ^bus_read_data;

    assign bus_read = 1'b0;

    // Corner ordering and clipping from the latched request, used in SETUP.
    always_comb begin
        xl_s   = (x0_q < x1_q) ? x0_q : x1_q;
        xmax_s = (x0_q < x1_q) ? x1_q : x0_q;
        xr_s   = (xmax_s > X_LAST) ? X_LAST : xmax_s;
        yt_s   = (y0_q < y1_q) ? y0_q : y1_q;
        ymax_s = (y0_q < y1_q) ? y1_q : y0_q;
        yb_s   = (ymax_s > Y_LAST) ? Y_LAST : ymax_s;
    end

    // FSM next state, coordinate counters and bus outputs.
    always_comb begin
        state_d         = state_q;
        x0_d            = x0_q;
        x1_d            = x1_q;
        y0_d            = y0_q;
        y1_d            = y1_q;
        color_d         = color_q;
        xl_d            = xl_q;
        xr_d            = xr_q;
        yt_d            = yt_q;
        yb_d            = yb_q;
        cx_d            = cx_q;
        cy_d            = cy_q;
        busy            = 1'b0;
        done            = 1'b0;
        bus_write       = 1'b0;
        bus_byte_enable = 1'b0;
        bus_write_data  = 8'h00;
        bus_address     = 30'h0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    x1_d    = x1;
                    y0_d    = y0;
                    y1_d    = y1;
                    color_d = color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                busy = 1'b1;
                xl_d = xl_s;
                xr_d = xr_s;
                yt_d = yt_s;
                yb_d = yb_s;
                if (xl_s >= X_END || yt_s >= Y_END) begin
                    state_d = DONE;
                end else begin
                    cx_d    = xl_s;
                    cy_d    = yt_s;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy            = 1'b1;
                bus_write       = 1'b1;
                bus_byte_enable = 1'b1;
                bus_write_data  = color_q;
                bus_address     = pix_addr(BASE_ADDR, cx_q, cy_q);
                if (bus_acknowledge) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                busy = 1'b1;
                if (abort || (cx_q == xr_q && cy_q == yb_q)) begin
                    state_d = DONE;
                end else if (cx_q == xr_q) begin
                    cx_d    = xl_q;
                    cy_d    = cy_q + Y_ONE;
                    state_d = WRITE;
                end else begin
                    cx_d    = cx_q + X_ONE;
                    state_d = WRITE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset returns to IDLE, dropping the strobe at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            xl_q    <= '0;
            xr_q    <= '0;
            yt_q    <= '0;
            yb_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            yt_q    <= yt_d;
            yb_q    <= yb_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

endmodule
